// File: rtl/noc_packet_responder_if.sv
// Flit handshake bundle between the NoC and the packet responder.
// The responder uses the slave modport; the NoC side (or a bench) uses master.
interface noc_packet_responder_if #(
    parameter int FLIT_WIDTH = 32
);
    logic [FLIT_WIDTH-1:0] rx_flit;
    logic                  rx_last;
    logic                  rx_valid;
    logic                  rx_ready;
    logic [FLIT_WIDTH-1:0] tx_flit;
    logic                  tx_last;
    logic                  tx_valid;
    logic                  tx_ready;

    modport slave (
        input  rx_flit, rx_last, rx_valid, tx_ready,
        output rx_ready, tx_flit, tx_last, tx_valid
    );

    modport master (
        output rx_flit, rx_last, rx_valid, tx_ready,
        input  rx_ready, tx_flit, tx_last, tx_valid
    );
endinterface

// File: rtl/noc_packet_responder.sv
// Store-and-forward NoC endpoint: buffers one packet, swaps dest/src in the header
// and returns it to the sender; misaddressed packets are dropped, oversize ones truncated.
module noc_packet_responder #(
    parameter int FLIT_WIDTH = 32,
    parameter int DEST_WIDTH = 5,
    parameter int NODE_ID    = 0,
    parameter int DEPTH      = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    noc_packet_responder_if.slave io,
    output logic [CNT_WIDTH-1:0] rx_pkt_count,
    output logic [CNT_WIDTH-1:0] drop_count,
    output logic [CNT_WIDTH-1:0] trunc_count
);
    localparam int FW = FLIT_WIDTH;
    localparam int DW = DEST_WIDTH;
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [DW-1:0] NODE_ADDR = NODE_ID[DW-1:0];

    localparam logic [0:0] ST_RX = 1'b0;
    localparam logic [0:0] ST_TX = 1'b1;

    logic [0:0]           state_q, state_d;
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]        len_q, len_d;
    logic                 trunc_q, trunc_d;
    logic [FW-1:0]        tx_flit_q, tx_flit_d;
    logic                 tx_last_q, tx_last_d;
    logic                 tx_valid_q, tx_valid_d;
    logic [CNT_WIDTH-1:0] rx_cnt_q, rx_cnt_d;
    logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
    logic [CNT_WIDTH-1:0] trunc_cnt_q, trunc_cnt_d;

    logic [FW-1:0] mem_q [DEPTH];

    logic          rx_hs_s;
    logic          tx_hs_s;
    logic          has_room_s;
    logic          mem_we_s;
    logic [FW-1:0] hdr_s;
    logic [PW-1:0] stored_len_s;
    logic          trunc_now_s;
    logic [PW-1:0] rd_next_s;

    function automatic logic [FW-1:0] rewrite_header(input logic [FW-1:0] f);
        return {f[FW-DW-1 -: DW], NODE_ADDR, f[FW-2*DW-1:0]};
    endfunction

    assign io.rx_ready   = (state_q == ST_RX);
    assign io.tx_flit    = tx_flit_q;
    assign io.tx_last    = tx_last_q;
    assign io.tx_valid   = tx_valid_q;
    assign rx_pkt_count  = rx_cnt_q;
    assign drop_count    = drop_cnt_q;
    assign trunc_count   = trunc_cnt_q;

    // Handshake qualifiers and packet bookkeeping derived from the current state.
    always_comb begin
        rx_hs_s      = (state_q == ST_RX) && io.rx_valid;
        tx_hs_s      = tx_valid_q && io.tx_ready;
        has_room_s   = (wr_ptr_q < PW'(DEPTH));
        mem_we_s     = rx_hs_s && has_room_s;
        // A single-flit packet's header is still on the bus, not yet in the buffer.
        hdr_s        = (wr_ptr_q == '0) ? io.rx_flit : mem_q[0];
        stored_len_s = has_room_s ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
        trunc_now_s  = trunc_q || !has_room_s;
        rd_next_s    = rd_ptr_q + PW'(1);
    end

    // Next-state logic for the receive/transmit phases and status counters.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        len_d       = len_q;
        trunc_d     = trunc_q;
        tx_flit_d   = tx_flit_q;
        tx_last_d   = tx_last_q;
        tx_valid_d  = tx_valid_q;
        rx_cnt_d    = rx_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        trunc_cnt_d = trunc_cnt_q;
        case (state_q)
            ST_RX: begin
                if (rx_hs_s) begin
                    if (io.rx_last) begin
                        wr_ptr_d = '0;
                        trunc_d  = 1'b0;
                        if (hdr_s[FW-1 -: DW] != NODE_ADDR) begin
                            drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
                        end else begin
                            rx_cnt_d = rx_cnt_q + CNT_WIDTH'(1);
                            if (trunc_now_s) begin
                                trunc_cnt_d = trunc_cnt_q + CNT_WIDTH'(1);
                            end else begin
                                trunc_cnt_d = trunc_cnt_q;
                            end
                            state_d    = ST_TX;
                            len_d      = stored_len_s;
                            rd_ptr_d   = '0;
                            tx_valid_d = 1'b1;
                            tx_flit_d  = rewrite_header(hdr_s);
                            tx_last_d  = (stored_len_s == PW'(1));
                        end
                    end else begin
                        wr_ptr_d = stored_len_s;
                        trunc_d  = trunc_now_s;
                    end
                end else begin
                    wr_ptr_d = wr_ptr_q;
                end
            end
            ST_TX: begin
                if (tx_hs_s) begin
                    if (tx_last_q) begin
                        state_d    = ST_RX;
                        rd_ptr_d   = '0;
                        wr_ptr_d   = '0;
                        tx_valid_d = 1'b0;
                        tx_last_d  = 1'b0;
                        tx_flit_d  = '0;
                    end else begin
                        rd_ptr_d  = rd_next_s;
                        tx_flit_d = mem_q[rd_next_s[AW-1:0]];
                        tx_last_d = (rd_next_s == (len_q - PW'(1)));
                    end
                end else begin
                    rd_ptr_d = rd_ptr_q;
                end
            end
            default: begin
                state_d    = ST_RX;
                wr_ptr_d   = '0;
                rd_ptr_d   = '0;
                trunc_d    = 1'b0;
                tx_valid_d = 1'b0;
                tx_last_d  = 1'b0;
                tx_flit_d  = '0;
            end
        endcase
    end

    // Control, output and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RX;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            len_q       <= '0;
            trunc_q     <= 1'b0;
            tx_flit_q   <= '0;
            tx_last_q   <= 1'b0;
            tx_valid_q  <= 1'b0;
            rx_cnt_q    <= '0;
            drop_cnt_q  <= '0;
            trunc_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            len_q       <= len_d;
            trunc_q     <= trunc_d;
            tx_flit_q   <= tx_flit_d;
            tx_last_q   <= tx_last_d;
            tx_valid_q  <= tx_valid_d;
            rx_cnt_q    <= rx_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            trunc_cnt_q <= trunc_cnt_d;
        end
    end

    // Packet buffer storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= io.rx_flit;
        end
    end
endmodule

// File: tb/tb_noc_packet_responder.sv
// Directed and randomized bench for noc_packet_responder (NODE_ID=3, DEPTH=16);
// expected responses come from a packet-level model of the echo rules.
module tb_noc_packet_responder;
    localparam int FW    = 32;
    localparam int DEPTH = 16;
    localparam logic [4:0] ME = 5'd3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] rx_pkt_count, drop_count, trunc_count;
    logic [15:0] exp_rx = 16'd0, exp_drop = 16'd0, exp_trunc = 16'd0;
    logic [31:0] pkt [40];
    int          n_tests = 0;
    int          n_fail  = 0;

    noc_packet_responder_if #(.FLIT_WIDTH(FW)) bus ();

    noc_packet_responder #(
        .FLIT_WIDTH(FW), .DEST_WIDTH(5), .NODE_ID(3), .DEPTH(DEPTH), .CNT_WIDTH(16)
    ) dut (
        .clk(clk), .rst(rst), .io(bus.slave),
        .rx_pkt_count(rx_pkt_count), .drop_count(drop_count), .trunc_count(trunc_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic make_pkt(input int n, input logic [4:0] dest, input logic [4:0] src);
        pkt[0] = {dest, src, 22'($urandom)};
        for (int i = 1; i < n; i++) pkt[i] = $urandom;
    endtask

    task automatic chk_counters();
        chk("rx_pkt_count", 64'(rx_pkt_count), 64'(exp_rx));
        chk("drop_count", 64'(drop_count), 64'(exp_drop));
        chk("trunc_count", 64'(trunc_count), 64'(exp_trunc));
    endtask

    // Called at a negedge; mode 0 = always ready, 1 = toggle, 2 = random.
    // stop_after >= 0 returns right after that many response handshakes.
    task automatic run_packet(input int n, input int mode, input int stop_after);
        logic [31:0] resp [DEPTH];
        int len, idx, cyc;
        bit acc;
        acc = (pkt[0][31:27] == ME);
        len = (n > DEPTH) ? DEPTH : n;
        resp[0] = {pkt[0][26:22], ME, pkt[0][21:0]};
        for (int i = 1; i < len; i++) resp[i] = pkt[i];
        for (int i = 0; i < n; i++) begin
            bus.rx_valid = 1'b1;
            bus.rx_flit  = pkt[i];
            bus.rx_last  = (i == n - 1);
            chk("rx_ready_rx", 64'(bus.rx_ready), 64'd1);
            chk("tx_valid_rx", 64'(bus.tx_valid), 64'd0);
            @(negedge clk);
        end
        bus.rx_valid = 1'b0;
        bus.rx_last  = 1'b0;
        if (!acc) begin
            exp_drop = exp_drop + 16'd1;
            chk("tx_valid_drop", 64'(bus.tx_valid), 64'd0);
            chk("rx_ready_drop", 64'(bus.rx_ready), 64'd1);
            chk_counters();
            return;
        end
        exp_rx = exp_rx + 16'd1;
        if (n > DEPTH) exp_trunc = exp_trunc + 16'd1;
        chk_counters();
        idx = 0;
        cyc = 0;
        while (idx < len && cyc < 1000) begin
            case (mode)
                0:       bus.tx_ready = 1'b1;
                1:       bus.tx_ready = cyc[0];
                default: bus.tx_ready = 1'($urandom_range(0, 1));
            endcase
            chk("tx_valid", 64'(bus.tx_valid), 64'd1);
            chk("tx_flit", 64'(bus.tx_flit), 64'(resp[idx]));
            chk("tx_last", 64'(bus.tx_last), 64'(idx == len - 1));
            chk("rx_ready_tx", 64'(bus.rx_ready), 64'd0);
            if (bus.tx_ready) idx++;
            cyc++;
            @(negedge clk);
            if (stop_after >= 0 && idx == stop_after) return;
        end
        chk("tx_done", 64'(idx), 64'(len));
        chk("rx_ready_after", 64'(bus.rx_ready), 64'd1);
        chk("tx_valid_after", 64'(bus.tx_valid), 64'd0);
        bus.tx_ready = 1'b0;
    endtask

    initial begin
        bus.rx_flit  = '0;
        bus.rx_last  = 1'b0;
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b0;
        #2;
        chk("rst_tx_valid", 64'(bus.tx_valid), 64'd0);
        chk("rst_tx_last", 64'(bus.tx_last), 64'd0);
        chk("rst_tx_flit", 64'(bus.tx_flit), 64'd0);
        chk_counters();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_rx_ready", 64'(bus.rx_ready), 64'd1);

        // Basic echo: dest=3 src=1 plus two payload flits.
        make_pkt(3, ME, 5'd1);
        run_packet(3, 0, -1);
        // Misaddressed packet is dropped silently.
        make_pkt(4, 5'd7, 5'd2);
        run_packet(4, 0, -1);
        chk("no_tx_after_drop", 64'(bus.tx_valid), 64'd0);
        // Oversize, then exactly DEPTH flits.
        make_pkt(20, ME, 5'd9);
        run_packet(20, 0, -1);
        make_pkt(16, ME, 5'd4);
        run_packet(16, 0, -1);
        make_pkt(17, ME, 5'd5);
        run_packet(17, 2, -1);
        // Backpressure toggling during a 4-flit response.
        make_pkt(4, ME, 5'd6);
        run_packet(4, 1, -1);
        // Single-flit followed back-to-back by a 2-flit packet.
        make_pkt(1, ME, 5'd10);
        run_packet(1, 0, -1);
        make_pkt(2, ME, 5'd11);
        run_packet(2, 0, -1);

        // Reset after one of three response flits.
        make_pkt(3, ME, 5'd12);
        run_packet(3, 0, 1);
        rst = 1'b1;
        #1;
        exp_rx = 16'd0;
        exp_drop = 16'd0;
        exp_trunc = 16'd0;
        chk("midrst_tx_valid", 64'(bus.tx_valid), 64'd0);
        chk("midrst_tx_last", 64'(bus.tx_last), 64'd0);
        chk("midrst_tx_flit", 64'(bus.tx_flit), 64'd0);
        chk_counters();
        @(negedge clk);
        rst = 1'b0;
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_rst_idle", 64'(bus.tx_valid), 64'd0);
        end
        make_pkt(3, ME, 5'd13);
        run_packet(3, 0, -1);

        // Randomized packets: lengths 1..20, occasional foreign dest, random stalls.
        for (int k = 0; k < 30; k++) begin
            int n;
            logic [4:0] d;
            n = $urandom_range(1, 20);
            d = ($urandom_range(0, 3) == 0) ? 5'($urandom) : ME;
            make_pkt(n, d, 5'($urandom));
            run_packet(n, $urandom_range(0, 2), -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
